seven_seg_scan: RTL and testbench
=================================

# seven_seg_scan

Parametrised multiplexed seven-segment display driver. It accepts a binary value through a load handshake and converts it to BCD with a sequential shift-add-3 engine. It then scans NUM_DIGITS digits out one at a time, with leading-zero blanking, per-digit decimal points, per-digit blinking and overflow indication. It sits between the counter/timer logic and the board display pins, and replaces the fixed 4-digit, two-field, every-cycle scanner.

## Interface
Parameters:
- NUM_DIGITS, 4: number of digits scanned (1..8); digit 0 is least significant, rightmost.
- VAL_W, 14: width of binary input value.
- SCAN_DIV, 1024: clock cycles each digit stays selected (>=1); SCAN_DIV=1 scans every cycle.
- BLINK_LOG2, 6: blink phase toggles every 2^BLINK_LOG2 completed scan rounds.

Ports:
- Clk  in  1  system clock; everything is on posedge Clk.
- Rst  in  1  synchronous, active-high reset.
- Val  in  VAL_W  binary value to display, sampled on an accepted Load.
- Load  in  1  load strobe; accepted only when Ready=1.
- Ready  out  1  high when the converter is idle and can accept Load.
- DpMask  in  NUM_DIGITS  bit i lights the decimal point of digit i; sampled live.
- BlinkMask  in  NUM_DIGITS  bit i makes digit i blink; sampled live.
- BlankEn  in  1  1 = blank leading zeros; sampled on an accepted Load.
- seg_sel  out  NUM_DIGITS  one-hot digit enable, active high, registered.
- seg_data  out  8  segment pattern; bit7=dp, bits6..0 = a,b,c,d,e,f,g, active high, registered.

## Operation
- Converter FSM has two states, IDLE and CONV.
  - IDLE: Ready=1. Load=1 latches Val and BlankEn, clears the BCD shift register, sets bit counter to VAL_W and moves to CONV.
  - CONV: Ready=0. Each cycle, add 3 to every BCD nibble >=5, then shift left one bit with the next Val MSB entering.
  - After VAL_W shifts the FSM returns to IDLE and the display register is updated atomically in that cycle.
- Load while in CONV is ignored; no queueing.
- Overflow: if Val > 10^NUM_DIGITS - 1, every digit shows a dash (8'b0000_0001, g only). The dp is still applied.
- Leading-zero blanking (BlankEn=1): zero digits above the most significant non-zero digit are blank (8'h00). Digit 0 is never blanked, so value 0 shows "0".
- Segment codes (bit7=0):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33
  - 5=5B, 6=5F, 7=70, 8=7F, 9=7B
  - blank=00, dash=01
  - Nibbles 10..15 cannot occur, but they must decode to blank.
- Scan: the prescaler counts 0..SCAN_DIV-1. On terminal count the digit index advances, wrapping NUM_DIGITS-1 -> 0. A wrap to 0 is a completed scan round.
- Blink: a round counter of BLINK_LOG2 bits counts completed scan rounds, and the blink phase toggles when it wraps. While phase=1, digits with BlinkMask=1 output 8'h00 including dp; seg_sel still pulses.
- Output formation: seg_data = {DpMask[idx], code[6:0]} unless blink-blanked; seg_sel = 1<<idx.

## Timing
- Reset values:
  - seg_sel = 1 (digit 0); seg_data = 8'h00.
  - Display register = all blank; Ready = 1; FSM = IDLE.
  - Prescaler, digit index, round counter and blink phase = 0.
- Load latency: Load accepted at edge k; Ready=0 from k+1 through k+VAL_W. The display register updates at edge k+VAL_W, and Ready=1 after that edge.
- The new value appears on seg_data the cycle after the display register updates, for the currently selected digit.
- seg_sel and seg_data are registered and change on the same edge, so no mixed-digit cycles occur.
- DpMask and BlinkMask take effect on the output one cycle after they change.
- Rst mid-conversion aborts the conversion, returns to reset state and drops the partial result.
- Rst has priority over Load in the same cycle.
- Load asserted on the same edge Ready rises: Ready must be registered high before a Load is accepted.

## Structure
- Package seven_seg_pkg holds:
  - the segment constants SEG_BLANK, SEG_DASH and SEG_DIGIT[0..9];
  - a function mapping a nibble to a 7-bit code (10..15 -> blank);
  - a function computing 10^N-1 for the overflow compare.
- Sub-module bin2bcd_seq (parameters VAL_W, NUM_DIGITS) contains the IDLE/CONV FSM.
  - Ports: Clk, Rst, start, bin, ready, done pulse, bcd[4*NUM_DIGITS-1:0], ovf.
- The top level contains the blanking logic, prescaler, digit counter, blink logic and output registers.

## Test plan
- Reset with SCAN_DIV=1, NUM_DIGITS=4 -> seg_sel=0001, seg_data=00, Ready=1; after 4 cycles seg_sel cycles 0010,0100,1000,0001.
- Load Val=1234, BlankEn=0 -> Ready low for 14 cycles. Then digits 0..3 show 33,79,6D,30; Load pulses during Ready=0 do not change the result.
- Load Val=7, BlankEn=1 -> digit0=70, digits 1..3=00. Load Val=0, BlankEn=1 -> digit0=7E, others 00.
- Load Val=10000 -> all four digits = 01. Then Load Val=9999 -> all digits = 7B.
- DpMask=0010, BlinkMask=0001, BLINK_LOG2=1, value 5 -> digit1 = 80|code; digit0 alternates 5B / 00 every 2 scan rounds.
- Rst asserted 5 cycles into conversion of 4321 -> all outputs at reset values, the display stays blank and Ready=1 on the next cycle.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types, segment encodings and helper functions for the seven-segment scanner.
package seven_seg_pkg;

    typedef enum logic {
        IDLE,
        CONV
    } convState_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h01;

    // Index 0 is the rightmost entry; bits are a,b,c,d,e,f,g from MSB to LSB.
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'h7B, 7'h7F, 7'h70, 7'h5F, 7'h5B,
        7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
    };

    function automatic logic [6:0] nibbleToSeg(input logic [3:0] nib);
        if (nib <= 4'd9)
            return SEG_DIGIT[nib];
        return SEG_BLANK;
    endfunction

    function automatic logic [63:0] maxDecimal(input int digits);
        logic [63:0] pow;
        pow = 64'd1;
        for (int i = 0; i < digits; i++)
            pow = pow * 64'd10;
        return pow - 64'd1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter with a load/ready handshake.
module bin2bcd_seq
    import seven_seg_pkg::*;
#(
    parameter int VAL_W      = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    start,
    input  logic [VAL_W-1:0]        bin,
    output logic                    ready,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    ovf
);

    localparam int BW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(VAL_W + 1);

    convState_t       r_state;
    logic [VAL_W-1:0] r_bin;
    logic [BW-1:0]    r_bcd;
    logic [CW-1:0]    r_cnt;
    logic             r_ovf;
    logic [BW-1:0]    w_adj;
    logic [BW-1:0]    w_next;

    // Digits above NUM_DIGITS are dropped; the overflow flag covers that case.
    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5)
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
        end
        w_next = {w_adj[BW-2:0], r_bin[VAL_W-1]};
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= CONV;
                        r_bin   <= bin;
                        r_bcd   <= '0;
                        r_cnt   <= CW'(VAL_W);
                        r_ovf   <= (64'(bin) > maxDecimal(NUM_DIGITS));
                    end
                end
                CONV: begin
                    r_bcd <= w_next;
                    r_bin <= r_bin << 1;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1))
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // done and bcd describe the final shift so the consumer can capture it on the same edge.
    assign ready = (r_state == IDLE);
    assign done  = (r_state == CONV) && (r_cnt == CW'(1));
    assign bcd   = w_next;
    assign ovf   = r_ovf;

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment driver: BCD conversion, leading-zero blanking,
// digit scanning, decimal points, blinking and overflow dashes.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int VAL_W      = 14,
    parameter int SCAN_DIV   = 1024,
    parameter int BLINK_LOG2 = 6
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [VAL_W-1:0]      Val,
    input  logic                  Load,
    output logic                  Ready,
    input  logic [NUM_DIGITS-1:0] DpMask,
    input  logic [NUM_DIGITS-1:0] BlinkMask,
    input  logic                  BlankEn,
    output logic [NUM_DIGITS-1:0] seg_sel,
    output logic [7:0]            seg_data
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                        w_done;
    logic                        w_ovf;
    logic [4*NUM_DIGITS-1:0]     w_bcd;
    logic                        w_seen;
    logic [NUM_DIGITS-1:0][6:0]  w_dispNext;
    logic [NUM_DIGITS-1:0][6:0]  r_disp;
    logic                        r_blankEn;
    logic [PW-1:0]               r_presc;
    logic [IW-1:0]               r_idx;
    logic [IW-1:0]               w_idxNext;
    logic [BLINK_LOG2-1:0]       r_round;
    logic                        r_phase;
    logic                        w_phaseNext;
    logic                        w_presTc;
    logic                        w_roundDone;

    bin2bcd_seq #(
        .VAL_W      (VAL_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .Clk   (Clk),
        .Rst   (Rst),
        .start (Load),
        .bin   (Val),
        .ready (Ready),
        .done  (w_done),
        .bcd   (w_bcd),
        .ovf   (w_ovf)
    );

    // Walk from the top digit down; once a non-zero nibble is seen nothing below is blanked.
    always_comb begin
        w_seen     = 1'b0;
        w_dispNext = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (w_bcd[4*i +: 4] != 4'd0)
                w_seen = 1'b1;
            if (w_ovf)
                w_dispNext[i] = SEG_DASH;
            else if (r_blankEn && !w_seen && (i != 0))
                w_dispNext[i] = SEG_BLANK;
            else
                w_dispNext[i] = nibbleToSeg(w_bcd[4*i +: 4]);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_blankEn <= 1'b0;
            r_disp    <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            if (Load && Ready)
                r_blankEn <= BlankEn;
            if (w_done)
                r_disp <= w_dispNext;
        end
    end

    assign w_presTc = (r_presc == PW'(SCAN_DIV - 1));

    always_comb begin
        w_idxNext   = r_idx;
        w_roundDone = 1'b0;
        if (w_presTc) begin
            if (r_idx == IW'(NUM_DIGITS - 1)) begin
                w_idxNext   = '0;
                w_roundDone = 1'b1;
            end else begin
                w_idxNext = r_idx + 1'b1;
            end
        end
        w_phaseNext = r_phase ^ (w_roundDone && (&r_round));
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_round <= '0;
            r_phase <= 1'b0;
        end else begin
            r_presc <= w_presTc ? '0 : r_presc + 1'b1;
            r_idx   <= w_idxNext;
            if (w_roundDone)
                r_round <= r_round + 1'b1;
            r_phase <= w_phaseNext;
        end
    end

    // Outputs follow the next index and phase so select and data move together.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            seg_sel  <= NUM_DIGITS'(1);
            seg_data <= 8'h00;
        end else begin
            seg_sel <= NUM_DIGITS'(1) << w_idxNext;
            if (w_phaseNext && BlinkMask[w_idxNext])
                seg_data <= 8'h00;
            else
                seg_data <= {DpMask[w_idxNext], r_disp[w_idxNext]};
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard testbench for seven_seg_scan with a fast scan and short blink period.
module tb_seven_seg_scan;

    localparam int ND = 4;
    localparam int VW = 14;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [VW-1:0] Val;
    logic          Load;
    logic          Ready;
    logic [ND-1:0] DpMask;
    logic [ND-1:0] BlinkMask;
    logic          BlankEn;
    logic [ND-1:0] seg_sel;
    logic [7:0]    seg_data;

    int checks = 0;
    int errors = 0;
    logic [11:0] expQ [$];

    seven_seg_scan #(
        .NUM_DIGITS (ND),
        .VAL_W      (VW),
        .SCAN_DIV   (1),
        .BLINK_LOG2 (1)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Val       (Val),
        .Load      (Load),
        .Ready     (Ready),
        .DpMask    (DpMask),
        .BlinkMask (BlinkMask),
        .BlankEn   (BlankEn),
        .seg_sel   (seg_sel),
        .seg_data  (seg_data)
    );

    always #5 Clk = ~Clk;

    function automatic logic [6:0] refCode(input int d);
        case (d)
            0: return 7'h7E;
            1: return 7'h30;
            2: return 7'h6D;
            3: return 7'h79;
            4: return 7'h33;
            5: return 7'h5B;
            6: return 7'h5F;
            7: return 7'h70;
            8: return 7'h7F;
            9: return 7'h7B;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [7:0] refDigit(input int v, input bit blank, input int i);
        int p;
        p = 1;
        for (int k = 0; k < i; k++)
            p = p * 10;
        if (v > 9999)
            return 8'h01;
        if (blank && (i > 0) && (v < p))
            return 8'h00;
        return {1'b0, refCode((v / p) % 10)};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pushExpected(input int v, input bit blank);
        for (int i = 0; i < ND; i++)
            expQ.push_back({4'(1 << i), refDigit(v, blank, i)});
    endtask

    // Loads one value, optionally pulsing Load during the conversion, and measures the busy window.
    task automatic applyStimulus(input int v, input bit blank, input bit spurious);
        int n;
        n = 0;
        while (!Ready && n < 100) begin
            tick();
            n++;
        end
        if (!Ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_wait Ready=%b required 1", Ready);
        end
        Val     = VW'(v);
        BlankEn = blank;
        Load    = 1'b1;
        tick();
        Load    = 1'b0;
        BlankEn = !blank;
        n = 0;
        while (!Ready && n < 100) begin
            if (spurious && (n == 2 || n == 5 || n == 9)) begin
                Load = 1'b1;
                Val  = 14'd9876;
            end else begin
                Load = 1'b0;
            end
            n++;
            tick();
        end
        Load = 1'b0;
        checks++;
        if (n !== VW) begin
            errors++;
            $display("[TB] FAIL ready_low value=%0d busy cycles=%0d required %0d", v, n, VW);
        end
    endtask

    // Aligns to digit 0 and pops one expected {sel,data} per scanned digit.
    task automatic checkOutput(input string name);
        int n;
        logic [11:0] e;
        tick();
        n = 0;
        while (seg_sel !== 4'b0001 && n < 50) begin
            tick();
            n++;
        end
        if (seg_sel !== 4'b0001) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_sync seg_sel=%b required 0001", name, seg_sel);
            expQ.delete();
            return;
        end
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            checks++;
            if ({seg_sel, seg_data} !== e) begin
                errors++;
                $display("[TB] FAIL %s sel=%b data=%h required sel=%b data=%h",
                         name, seg_sel, seg_data, e[11:8], e[7:0]);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        logic [ND-1:0] expSel;
        Rst = 1'b1; Load = 1'b0; Val = '0; BlankEn = 1'b0;
        DpMask = '0; BlinkMask = '0;
        tick();
        tick();
        checks++;
        if (seg_sel !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL reset_sel seg_sel=%b required 0001", seg_sel);
        end
        checks++;
        if (seg_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_data seg_data=%h required 00", seg_data);
        end
        checks++;
        if (Ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready Ready=%b required 1", Ready);
        end
        Rst = 1'b0;
        for (int i = 1; i <= ND; i++) begin
            tick();
            expSel = 4'(1 << (i % ND));
            checks++;
            if (seg_sel !== expSel || seg_data !== 8'h00) begin
                errors++;
                $display("[TB] FAIL scan_seq step=%0d sel=%b data=%h required sel=%b data=00",
                         i, seg_sel, seg_data, expSel);
            end
        end
    endtask

    task automatic test_count();
        applyStimulus(1234, 1'b0, 1'b1);
        pushExpected(1234, 1'b0);
        checkOutput("val1234");
    endtask

    task automatic test_blanking();
        applyStimulus(7, 1'b1, 1'b0);
        pushExpected(7, 1'b1);
        checkOutput("val7_blank");
        applyStimulus(0, 1'b1, 1'b0);
        pushExpected(0, 1'b1);
        checkOutput("val0_blank");
        applyStimulus(305, 1'b0, 1'b0);
        pushExpected(305, 1'b0);
        checkOutput("val305");
    endtask

    task automatic test_overflow();
        applyStimulus(10000, 1'b0, 1'b0);
        pushExpected(10000, 1'b0);
        checkOutput("ovf10000");
        applyStimulus(9999, 1'b1, 1'b0);
        pushExpected(9999, 1'b1);
        checkOutput("val9999");
    endtask

    task automatic test_blink();
        logic [7:0] d0 [12];
        int t;
        int n;
        logic [7:0] want;
        DpMask    = 4'b0011;
        BlinkMask = 4'b0001;
        applyStimulus(5, 1'b0, 1'b0);
        tick();
        n = 0;
        while (seg_sel !== 4'b0001 && n < 50) begin
            tick();
            n++;
        end
        for (int r = 0; r < 12; r++) begin
            d0[r] = seg_data;
            tick();
            expQ.push_back({4'b0010, 8'hFE});
            expQ.push_back({4'b0100, 8'h7E});
            expQ.push_back({4'b1000, 8'h7E});
            for (int k = 0; k < 3; k++) begin
                logic [11:0] e;
                e = expQ.pop_front();
                checks++;
                if ({seg_sel, seg_data} !== e) begin
                    errors++;
                    $display("[TB] FAIL blink_other round=%0d sel=%b data=%h required sel=%b data=%h",
                             r, seg_sel, seg_data, e[11:8], e[7:0]);
                end
                tick();
            end
        end
        t = 0;
        for (int r = 11; r >= 1; r--)
            if (d0[r] !== d0[r-1])
                t = r;
        checks++;
        if (t == 0) begin
            errors++;
            $display("[TB] FAIL blink_toggle digit0=%h never changed, required alternation DB/00", d0[0]);
        end else begin
            checks++;
            if (!((d0[t] === 8'hDB && d0[t-1] === 8'h00) || (d0[t] === 8'h00 && d0[t-1] === 8'hDB))) begin
                errors++;
                $display("[TB] FAIL blink_values digit0=%h then %h required DB and 00", d0[t-1], d0[t]);
            end
            for (int j = t; j < 12; j++) begin
                want = (((j - t) / 2) % 2 == 0) ? d0[t] : d0[t-1];
                checks++;
                if (d0[j] !== want) begin
                    errors++;
                    $display("[TB] FAIL blink_period round=%0d digit0=%h required %h", j, d0[j], want);
                end
            end
        end
        DpMask    = '0;
        BlinkMask = '0;
    endtask

    task automatic test_reset_mid_conv();
        int n;
        n = 0;
        while (!Ready && n < 100) begin
            tick();
            n++;
        end
        Val  = 14'd4321;
        Load = 1'b1;
        tick();
        Load = 1'b0;
        for (int i = 0; i < 4; i++)
            tick();
        Rst  = 1'b1;
        Load = 1'b1;
        tick();
        checks++;
        if (seg_sel !== 4'b0001 || seg_data !== 8'h00 || Ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset sel=%b data=%h ready=%b required sel=0001 data=00 ready=1",
                     seg_sel, seg_data, Ready);
        end
        Rst  = 1'b0;
        Load = 1'b0;
        tick();
        checks++;
        if (Ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset_ready Ready=%b required 1", Ready);
        end
        for (int i = 0; i < 20; i++)
            tick();
        for (int i = 0; i < ND; i++)
            expQ.push_back({4'(1 << i), 8'h00});
        checkOutput("after_reset_blank");
    endtask

    initial begin
        test_reset();
        test_count();
        test_blanking();
        test_overflow();
        test_blink();
        test_reset_mid_conv();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
